decoder_strobe_2to4: RTL and testbench
======================================

// Module: decoder_strobe_2to4
// PURPOSE
//  Registered 2-to-4 decoder. It is the inverse of the team's 4-to-2 encoder.
//  Accepts a binary code A through a valid/ready handshake and drives the
//  matching one-hot line of Y for HOLD clock cycles. It then releases the line
//  and pulses done. Used to strobe one of four select/enable lines per token.
//  A loopback through the 4-to-2 encoder must recover A.
// PARAMETERS
//  IN_W   2   width of binary input code
//  HOLD   4   cycles each decoded line stays high; legal range 1..255
//  OUT_W  (localparam) = 1<<IN_W; one-hot output width (4 at default)
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  A           in   IN_W   binary code to decode
//  a_valid     in   1      A is valid this cycle
//  a_ready     out  1      block can accept A; = (state==IDLE) && en
//  en          in   1      global enable; low pauses accepts and hold countdown
//  Y           out  OUT_W  one-hot decoded output (registered)
//  busy        out  1      high while a line is being held (state HOLD)
//  done        out  1      single-cycle pulse, first cycle after a line is released
//  decode_cnt  out  8      count of accepted codes; wraps 255->0
// BEHAVIOUR
//  Reset (async, immediate): Y=0, busy=0, done=0, decode_cnt=0, hold counter=0.
//   State goes to IDLE, so a_ready follows en. In-flight holds are aborted and
//   no done pulse is issued for them.
//  States: IDLE, HOLD.
//  IDLE:
//   - Accept happens on a rising edge where a_valid && a_ready.
//   - On that edge: Y <= 1<<A, busy <= 1, cnt <= HOLD-1, decode_cnt <= +1,
//     state -> HOLD.
//   - Latency is 1 cycle from the accept edge to Y valid.
//  HOLD:
//   - a_ready=0. a_valid/A are ignored and not captured; the source must keep
//     a_valid asserted until the handshake completes.
//   - While en=1: if cnt!=0, cnt <= cnt-1. If cnt==0, on that edge Y <= 0,
//     busy <= 0, done <= 1, state -> IDLE.
//   - While en=0: cnt frozen, Y held, no transition.
//  done: set only on the HOLD->IDLE edge; cleared on the following edge.
//  Y is high for exactly HOLD enabled cycles (HOLD=1: single-cycle strobe).
//   Back-to-back tokens: min spacing HOLD+1 cycles, with one all-zero Y cycle
//   (done=1, a_ready=en) between lines.
//  Accept in the done cycle is legal; the new Y appears on the next edge.
//  Invariants: Y is always one-hot or zero; busy == (Y!=0); no X on any
//   output after reset.
//  en low in IDLE: a_ready=0, no accept, outputs unchanged.
//  Width rules: A is zero-extended into the shift; decode_cnt is an 8-bit
//   modulo counter.
// TESTING
//  1 reset; A=2'b10, a_valid 1 cycle -> Y=4'b0100 for 4 cycles, busy=1;
//    then Y=0, done=1 one cycle; decode_cnt=1
//  2 a_valid held high, A stepped 0..3 per accept -> Y=0001,0010,0100,1000,
//    each 4 cycles, 1 zero cycle between; Y fed to 4-to-2 encoder returns A
//  3 accept A=2'b01, drop en for 3 cycles mid-HOLD -> Y=4'b0010 high 7
//    cycles total; a_ready=0 throughout
//  4 assert rst between clock edges during HOLD -> Y=0, busy=0,
//    decode_cnt=0 before next edge; no done pulse
//  5 256 back-to-back accepts -> decode_cnt reads 255 then wraps to 0
//  6 during HOLD of A=2'b11, drive a_valid=1, A=2'b00 -> Y stays 4'b1000,
//    a_ready=0; A=00 is accepted only in the done cycle

Source files
------------

// File: rtl/decoder_strobe_2to4.sv
// Registered 2-to-4 decoder: accepts a code via valid/ready, strobes the
// matching one-hot line of Y for HOLD enabled cycles, then pulses done.
module decoder_strobe_2to4 #(
    parameter int IN_W = 2,
    parameter int HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_W-1:0]      A,
    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic                 en,
    output logic [(1<<IN_W)-1:0] Y,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           decode_cnt
);

    localparam int OUT_W = 1 << IN_W;

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_HOLD = 1'b1;

    localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);
    localparam logic [OUT_W-1:0] ONE_HOT_0 = OUT_W'(1);

    logic [0:0] state;
    logic [7:0] cnt;

    assign a_ready = (state == STATE_IDLE) && en;

    // done defaults low each edge so it only survives the cycle after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= STATE_IDLE;
            cnt        <= 8'd0;
            Y          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            decode_cnt <= 8'd0;
        end else begin
            done <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (a_valid && a_ready) begin
                        Y          <= ONE_HOT_0 << A;
                        busy       <= 1'b1;
                        cnt        <= HOLD_LAST;
                        decode_cnt <= decode_cnt + 8'd1;
                        state      <= STATE_HOLD;
                    end
                end
                STATE_HOLD: begin
                    if (en) begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            Y     <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= STATE_IDLE;
                        end
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_strobe_2to4.sv
// Directed self-checking bench for decoder_strobe_2to4 at default parameters.
module tb_decoder_strobe_2to4;

    logic       clk;
    logic       rst;
    logic [1:0] A;
    logic       a_valid;
    logic       a_ready;
    logic       en;
    logic [3:0] Y;
    logic       busy;
    logic       done;
    logic [7:0] decode_cnt;

    int passed = 0;
    int total  = 0;

    decoder_strobe_2to4 #(.IN_W(2), .HOLD(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .en         (en),
        .Y          (Y),
        .busy       (busy),
        .done       (done),
        .decode_cnt (decode_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference 4-to-2 encoder used for the loopback check
    function automatic logic [1:0] enc4to2(input logic [3:0] y);
        case (y)
            4'b0001: return 2'd0;
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'bxx;
        endcase
    endfunction

    // Outputs are sampled 1 time unit after each rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; a_valid = 1'b0; A = 2'd0;
        step();
        total++; if (Y !== 4'b0000) $display("[TB] FAIL reset_y got=%b exp=0000", Y); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got=%b exp=0", busy); else passed++;
        total++; if (done !== 1'b0) $display("[TB] FAIL reset_done got=%b exp=0", done); else passed++;
        total++; if (decode_cnt !== 8'd0) $display("[TB] FAIL reset_cnt got=%0d exp=0", decode_cnt); else passed++;
        total++; if (a_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%b exp=1", a_ready); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        A = 2'b10; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (Y !== 4'b0100) $display("[TB] FAIL single_y[%0d] got=%b exp=0100", i, Y); else passed++;
            total++; if (busy !== 1'b1) $display("[TB] FAIL single_busy[%0d] got=%b exp=1", i, busy); else passed++;
            total++; if (a_ready !== 1'b0) $display("[TB] FAIL single_ready[%0d] got=%b exp=0", i, a_ready); else passed++;
            step();
        end
        total++; if (Y !== 4'b0000) $display("[TB] FAIL single_rel_y got=%b exp=0000", Y); else passed++;
        total++; if (done !== 1'b1) $display("[TB] FAIL single_done got=%b exp=1", done); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL single_rel_busy got=%b exp=0", busy); else passed++;
        step();
        total++; if (done !== 1'b0) $display("[TB] FAIL single_done_clr got=%b exp=0", done); else passed++;
        total++; if (decode_cnt !== 8'd1) $display("[TB] FAIL single_cnt got=%0d exp=1", decode_cnt); else passed++;
    endtask

    task automatic test_stream();
        logic [3:0] exp_y;
        A = 2'd0; a_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_y = 4'b0001 << k;
            step();
            for (int i = 0; i < 4; i++) begin
                total++; if (Y !== exp_y) $display("[TB] FAIL stream_y k=%0d i=%0d got=%b exp=%b", k, i, Y, exp_y); else passed++;
                total++; if (enc4to2(Y) !== 2'(k)) $display("[TB] FAIL stream_loop k=%0d got=%0d exp=%0d", k, enc4to2(Y), k); else passed++;
                step();
            end
            total++; if (Y !== 4'b0000) $display("[TB] FAIL stream_gap_y k=%0d got=%b exp=0000", k, Y); else passed++;
            total++; if (done !== 1'b1) $display("[TB] FAIL stream_gap_done k=%0d got=%b exp=1", k, done); else passed++;
            total++; if (a_ready !== 1'b1) $display("[TB] FAIL stream_gap_ready k=%0d got=%b exp=1", k, a_ready); else passed++;
            if (k < 3) A = 2'(k + 1);
            else a_valid = 1'b0;
        end
        step();
        total++; if (decode_cnt !== 8'd5) $display("[TB] FAIL stream_cnt got=%0d exp=5", decode_cnt); else passed++;
    endtask

    task automatic test_enable_pause();
        int high_cycles;
        int guard;
        A = 2'b01; a_valid = 1'b1; en = 1'b1;
        step();
        a_valid = 1'b0;
        high_cycles = 0;
        guard = 0;
        while (Y !== 4'b0000 && guard < 20) begin
            total++; if (Y !== 4'b0010) $display("[TB] FAIL pause_y s=%0d got=%b exp=0010", guard, Y); else passed++;
            total++; if (a_ready !== 1'b0) $display("[TB] FAIL pause_ready s=%0d got=%b exp=0", guard, a_ready); else passed++;
            high_cycles++;
            en = !(guard >= 1 && guard <= 3);
            guard++;
            step();
        end
        en = 1'b1;
        total++; if (high_cycles !== 7) $display("[TB] FAIL pause_len got=%0d exp=7", high_cycles); else passed++;
        total++; if (done !== 1'b1) $display("[TB] FAIL pause_done got=%b exp=1", done); else passed++;
        step();
        // en low in IDLE must block accepts
        en = 1'b0; a_valid = 1'b1; A = 2'b11;
        #1;
        total++; if (a_ready !== 1'b0) $display("[TB] FAIL idle_en_ready got=%b exp=0", a_ready); else passed++;
        step();
        step();
        total++; if (Y !== 4'b0000) $display("[TB] FAIL idle_en_y got=%b exp=0000", Y); else passed++;
        total++; if (decode_cnt !== 8'd6) $display("[TB] FAIL idle_en_cnt got=%0d exp=6", decode_cnt); else passed++;
        a_valid = 1'b0; en = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        A = 2'b11; a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        total++; if (Y !== 4'b0000) $display("[TB] FAIL areset_y got=%b exp=0000", Y); else passed++;
        total++; if (busy !== 1'b0) $display("[TB] FAIL areset_busy got=%b exp=0", busy); else passed++;
        total++; if (decode_cnt !== 8'd0) $display("[TB] FAIL areset_cnt got=%0d exp=0", decode_cnt); else passed++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            total++; if (done !== 1'b0 || Y !== 4'b0000) $display("[TB] FAIL areset_nodone i=%0d done=%b y=%b exp done=0 y=0000", i, done, Y); else passed++;
        end
    endtask

    task automatic test_wrap();
        A = 2'b01; a_valid = 1'b1;
        for (int n = 1; n <= 256; n++) begin
            step();
            if (n == 255) begin
                total++; if (decode_cnt !== 8'd255) $display("[TB] FAIL wrap_255 got=%0d exp=255", decode_cnt); else passed++;
            end
            if (n == 256) begin
                total++; if (decode_cnt !== 8'd0) $display("[TB] FAIL wrap_0 got=%0d exp=0", decode_cnt); else passed++;
            end
            repeat (4) step();
        end
        a_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        A = 2'b11; a_valid = 1'b1;
        step();
        A = 2'b00;
        for (int i = 0; i < 4; i++) begin
            total++; if (Y !== 4'b1000) $display("[TB] FAIL b2b_hold_y i=%0d got=%b exp=1000", i, Y); else passed++;
            total++; if (a_ready !== 1'b0) $display("[TB] FAIL b2b_ready i=%0d got=%b exp=0", i, a_ready); else passed++;
            step();
        end
        total++; if (Y !== 4'b0000) $display("[TB] FAIL b2b_gap_y got=%b exp=0000", Y); else passed++;
        total++; if (done !== 1'b1 || a_ready !== 1'b1) $display("[TB] FAIL b2b_gap done=%b ready=%b exp 1/1", done, a_ready); else passed++;
        step();
        a_valid = 1'b0;
        total++; if (Y !== 4'b0001) $display("[TB] FAIL b2b_next_y got=%b exp=0001", Y); else passed++;
        total++; if (decode_cnt !== 8'd2) $display("[TB] FAIL b2b_cnt got=%0d exp=2", decode_cnt); else passed++;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_enable_pause();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
